// File: rtl/mem_arb_2p_if.sv
// Bundle of the two requester ports and the memory port of mem_arb_2p.
// The slave modport is the arbiter's view; master is the environment
// (requesters and memory) driving the arbiter.
interface mem_arb_2p_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                  req0_valid_i;
    logic                  req0_wr_i;
    logic [ADDR_WIDTH-1:0] req0_addr_i;
    logic [WIDTH-1:0]      req0_wdata_i;
    logic                  req0_ready_o;
    logic [WIDTH-1:0]      req0_rdata_o;
    logic                  req0_err_o;

    logic                  req1_valid_i;
    logic                  req1_wr_i;
    logic [ADDR_WIDTH-1:0] req1_addr_i;
    logic [WIDTH-1:0]      req1_wdata_i;
    logic                  req1_ready_o;
    logic [WIDTH-1:0]      req1_rdata_o;
    logic                  req1_err_o;

    logic                  mem_valid_o;
    logic                  mem_wr_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [WIDTH-1:0]      mem_wdata_o;
    logic                  mem_ready_i;
    logic [WIDTH-1:0]      mem_rdata_i;

    modport slave (
        input  req0_valid_i, req0_wr_i, req0_addr_i, req0_wdata_i,
        output req0_ready_o, req0_rdata_o, req0_err_o,
        input  req1_valid_i, req1_wr_i, req1_addr_i, req1_wdata_i,
        output req1_ready_o, req1_rdata_o, req1_err_o,
        output mem_valid_o, mem_wr_o, mem_addr_o, mem_wdata_o,
        input  mem_ready_i, mem_rdata_i
    );

    modport master (
        output req0_valid_i, req0_wr_i, req0_addr_i, req0_wdata_i,
        input  req0_ready_o, req0_rdata_o, req0_err_o,
        output req1_valid_i, req1_wr_i, req1_addr_i, req1_wdata_i,
        input  req1_ready_o, req1_rdata_o, req1_err_o,
        input  mem_valid_o, mem_wr_o, mem_addr_o, mem_wdata_o,
        output mem_ready_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_arb_2p.sv
// Two-requester round-robin arbiter in front of a single-port valid/ready
// memory. One access outstanding at a time; a stuck memory handshake is
// aborted after TIMEOUT cycles and reported through the winner's err flag.
module mem_arb_2p #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 15
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    mem_arb_2p_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_grant;
    logic       winner;
    logic [7:0] cnt;
    logic       pick;

    // Round-robin choice: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        pick = 1'b0;
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            pick = ~last_grant;
        end else if (bus.req1_valid_i) begin
            pick = 1'b1;
        end
    end

    // Control FSM with registered memory-port and requester-response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            winner           <= 1'b0;
            cnt              <= '0;
            bus.mem_valid_o  <= 1'b0;
            bus.mem_wr_o     <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.mem_wdata_o  <= '0;
            bus.req0_ready_o <= 1'b0;
            bus.req0_rdata_o <= '0;
            bus.req0_err_o   <= 1'b0;
            bus.req1_ready_o <= 1'b0;
            bus.req1_rdata_o <= '0;
            bus.req1_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0_valid_i || bus.req1_valid_i) begin
                        winner          <= pick;
                        last_grant      <= pick;
                        bus.mem_valid_o <= 1'b1;
                        bus.mem_wr_o    <= pick ? bus.req1_wr_i    : bus.req0_wr_i;
                        bus.mem_addr_o  <= pick ? bus.req1_addr_i  : bus.req0_addr_i;
                        bus.mem_wdata_o <= pick ? bus.req1_wdata_i : bus.req0_wdata_i;
                        state           <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready_i) begin
                        bus.mem_valid_o <= 1'b0;
                        cnt             <= '0;
                        state           <= RESP;
                        if (winner) begin
                            bus.req1_ready_o <= 1'b1;
                            bus.req1_err_o   <= 1'b0;
                            if (!bus.mem_wr_o) bus.req1_rdata_o <= bus.mem_rdata_i;
                        end else begin
                            bus.req0_ready_o <= 1'b1;
                            bus.req0_err_o   <= 1'b0;
                            if (!bus.mem_wr_o) bus.req0_rdata_o <= bus.mem_rdata_i;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // Memory never answered: abort and flag, read data left untouched.
                        bus.mem_valid_o <= 1'b0;
                        cnt             <= '0;
                        state           <= RESP;
                        if (winner) begin
                            bus.req1_ready_o <= 1'b1;
                            bus.req1_err_o   <= 1'b1;
                        end else begin
                            bus.req0_ready_o <= 1'b1;
                            bus.req0_err_o   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    bus.req0_ready_o <= 1'b0;
                    bus.req1_ready_o <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arb_2p.sv
// Scoreboard bench for mem_arb_2p: stimulus pushes expected responses,
// a negedge monitor pops them whenever a requester ready pulse appears.
module tb_mem_arb_2p;
    localparam int WIDTH   = 16;
    localparam int AW      = 6;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] mem [64];
    int          mem_delay = 0;
    bit          mem_hang = 1'b0;
    int          wait_cnt = 0;

    always #5 clk = ~clk;

    mem_arb_2p_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

    mem_arb_2p #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input bit p);
        return p ? bus.req1_ready_o : bus.req0_ready_o;
    endfunction

    // Memory model: answers after mem_delay waiting cycles unless hung.
    always @(negedge clk) begin
        bus.mem_ready_i = 1'b0;
        if (bus.mem_valid_o && !mem_hang) begin
            if (wait_cnt == mem_delay) begin
                bus.mem_ready_i = 1'b1;
                bus.mem_rdata_i = mem[bus.mem_addr_o];
                if (bus.mem_wr_o) mem[bus.mem_addr_o] = bus.mem_wdata_o;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic pop(input bit p);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: port %0d got ready expected none", p);
        end else begin
            e = sb.pop_front();
            check("resp_port", 32'(p), 32'(e.port));
            check("resp_err", 32'(p ? bus.req1_err_o : bus.req0_err_o), 32'(e.err));
            check("resp_rdata", 32'(p ? bus.req1_rdata_o : bus.req0_rdata_o), 32'(e.rdata));
        end
    endtask

    // Monitor: compare every ready pulse against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req0_ready_o || bus.req1_ready_o) begin
                check("ready_exclusive", 32'(bus.req0_ready_o & bus.req1_ready_o), 32'd0);
                check("valid_during_ready", 32'(bus.mem_valid_o), 32'd0);
            end
            if (bus.req0_ready_o) pop(1'b0);
            if (bus.req1_ready_o) pop(1'b1);
        end
    end

    task automatic issue(input bit p, input bit wr, input logic [5:0] a, input logic [15:0] d);
        if (!p) begin
            bus.req0_valid_i = 1'b1; bus.req0_wr_i = wr; bus.req0_addr_i = a; bus.req0_wdata_i = d;
        end else begin
            bus.req1_valid_i = 1'b1; bus.req1_wr_i = wr; bus.req1_addr_i = a; bus.req1_wdata_i = d;
        end
    endtask

    task automatic wait_done(input bit p, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy(p)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: no ready within bound, expected ready", name);
        end
        @(posedge clk);
        #1;
        if (!p) bus.req0_valid_i = 1'b0;
        else    bus.req1_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcyc;
        int acyc;
        bit got;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        bus.req0_valid_i = 0; bus.req0_wr_i = 0; bus.req0_addr_i = '0; bus.req0_wdata_i = '0;
        bus.req1_valid_i = 0; bus.req1_wr_i = 0; bus.req1_addr_i = '0; bus.req1_wdata_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_valid", 32'(bus.mem_valid_o), 0);
        check("rst_ready0", 32'(bus.req0_ready_o), 0);
        check("rst_ready1", 32'(bus.req1_ready_o), 0);
        check("rst_err0", 32'(bus.req0_err_o), 0);
        check("rst_rdata1", 32'(bus.req1_rdata_o), 0);
        check("rst_mem_addr", 32'(bus.mem_addr_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write with latency checks
        @(posedge clk); #1;
        issue(1'b0, 1'b1, 6'd5, 16'hA5A5);
        sb.push_back('{port: 1'b0, err: 1'b0, rdata: 16'h0000});
        @(posedge clk); #1;
        check("w_mem_valid", 32'(bus.mem_valid_o), 1);
        check("w_mem_addr", 32'(bus.mem_addr_o), 5);
        check("w_mem_wdata", 32'(bus.mem_wdata_o), 32'hA5A5);
        check("w_mem_wr", 32'(bus.mem_wr_o), 1);
        @(posedge clk); #1;
        check("w_ready_pulse", 32'(bus.req0_ready_o), 1);
        check("w_err", 32'(bus.req0_err_o), 0);
        check("w_mem_valid_low", 32'(bus.mem_valid_o), 0);
        bus.req0_valid_i = 1'b0;
        @(posedge clk); #1;
        check("w_ready_one_cycle", 32'(bus.req0_ready_o), 0);

        // Write/read-back on requester 1, including address wrap 63 -> 0
        issue(1'b1, 1'b1, 6'd63, 16'h1234); sb.push_back('{1'b1, 1'b0, 16'h0000}); wait_done(1'b1, "wr63");
        issue(1'b1, 1'b1, 6'd0, 16'hBEEF);  sb.push_back('{1'b1, 1'b0, 16'h0000}); wait_done(1'b1, "wr0");
        issue(1'b1, 1'b0, 6'd63, 16'h0);    sb.push_back('{1'b1, 1'b0, 16'h1234}); wait_done(1'b1, "rd63");
        issue(1'b1, 1'b0, 6'd0, 16'h0);     sb.push_back('{1'b1, 1'b0, 16'hBEEF}); wait_done(1'b1, "rd0");
        issue(1'b0, 1'b0, 6'd5, 16'h0);     sb.push_back('{1'b0, 1'b0, 16'hA5A5}); wait_done(1'b0, "rd5");

        // Contention after a fresh reset: req0 writes, req1 reads the same slot right after
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{1'b0, 1'b0, 16'h0000});
            sb.push_back('{1'b1, 1'b0, 16'(16'h1000 + i)});
        end
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    issue(1'b0, 1'b1, 6'(16 + i), 16'(16'h1000 + i));
                    wait_done(1'b0, "cont0");
                end
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    issue(1'b1, 1'b0, 6'(16 + j), 16'h0);
                    wait_done(1'b1, "cont1");
                end
            end
        join
        check("cont_all_consumed", 32'(sb.size()), 0);

        // Timeout with a hung memory, then a normal access
        mem_hang = 1'b1;
        issue(1'b0, 1'b0, 6'd5, 16'h0);
        sb.push_back('{1'b0, 1'b1, 16'h0000});
        vcyc = 0;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.req0_ready_o) begin
                got = 1'b1;
                break;
            end
            if (bus.mem_valid_o) vcyc++;
        end
        check("to_ready_seen", 32'(got), 1);
        check("to_cycles", 32'(vcyc), TIMEOUT);
        check("to_err", 32'(bus.req0_err_o), 1);
        check("to_mem_valid", 32'(bus.mem_valid_o), 0);
        @(posedge clk); #1;
        bus.req0_valid_i = 1'b0;
        mem_hang = 1'b0;
        issue(1'b0, 1'b0, 6'd5, 16'h0); sb.push_back('{1'b0, 1'b0, 16'hA5A5}); wait_done(1'b0, "after_to");

        // Stall: memory answers on the 4th access cycle; request must stay stable
        mem_delay = 3;
        issue(1'b1, 1'b1, 6'd40, 16'h5A5A);
        sb.push_back('{1'b1, 1'b0, 16'h1007});
        acyc = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.mem_valid_o) begin
                acyc++;
                check("stall_addr", 32'(bus.mem_addr_o), 40);
                check("stall_wdata", 32'(bus.mem_wdata_o), 32'h5A5A);
                check("stall_wr", 32'(bus.mem_wr_o), 1);
            end
            if (bus.req1_ready_o) break;
        end
        check("stall_cycles", 32'(acyc), 4);
        @(posedge clk); #1;
        bus.req1_valid_i = 1'b0;
        mem_delay = 0;
        issue(1'b1, 1'b0, 6'd40, 16'h0); sb.push_back('{1'b1, 1'b0, 16'h5A5A}); wait_done(1'b1, "rd40");

        // Asynchronous reset in the middle of an access
        mem_hang = 1'b1;
        issue(1'b1, 1'b0, 6'd7, 16'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); #2;
        check("pre_rst_mem_valid", 32'(bus.mem_valid_o), 1);
        rst_n = 1'b0;
        #1;
        check("arst_mem_valid", 32'(bus.mem_valid_o), 0);
        check("arst_ready0", 32'(bus.req0_ready_o), 0);
        check("arst_ready1", 32'(bus.req1_ready_o), 0);
        bus.req1_valid_i = 1'b0;
        mem_hang = 1'b0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{1'b0, 1'b0, 16'h0000});
        sb.push_back('{1'b1, 1'b0, 16'h0000});
        issue(1'b0, 1'b1, 6'd50, 16'h0550);
        issue(1'b1, 1'b1, 6'd51, 16'h0551);
        fork
            wait_done(1'b0, "tie0");
            wait_done(1'b1, "tie1");
        join
        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 0);
        check("mem50", 32'(mem[50]), 32'h0550);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
